// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the FSM state enum, default byte width and command framing bytes.
package uart_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int DATA_W_DFLT = 8;

    // Framing bytes shared with the command translator.
    localparam logic [7:0] CMD_SOF = 8'h24;
    localparam logic [7:0] CMD_SEP = 8'h2C;
    localparam logic [7:0] CMD_EOF = 8'h0A;

    function automatic logic is_frame_end(input logic [7:0] b);
        return b == CMD_EOF;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter handshake bundle for the UART transmit arbiter.
// master: requesters + uart_tx side; slave: the arbiter itself.
interface uart_arb_if
    import uart_arb_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int DATA_W = DATA_W_DFLT
);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]       tx_data;
    logic                    tx_valid;
    logic                    tx_ready;

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        output tx_ready,
        input  req_ready,
        input  tx_data,
        input  tx_valid
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        input  tx_ready,
        output req_ready,
        output tx_data,
        output tx_valid
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotate-priority search: first set req bit above ptr.
// Ports: req (request vector), ptr (last winner), idx (winner), found.
module rr_pick #(
    parameter int  N_REQ = 3,
    localparam int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    idx,
    output logic             found
);

    logic [PW-1:0] cand;

    always_comb begin
        cand  = '0;
        idx   = '0;
        found = 1'b0;
        // Visit ptr+1 .. ptr+N_REQ (mod N_REQ); ptr itself is checked last.
        for (int k = 1; k <= N_REQ; k++) begin
            cand = PW'((int'(ptr) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Per-message round-robin arbiter in front of the single uart_tx.
// Ports: clk, reset_n, bus (slave handshakes), grant_id, busy, timeout_err.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int  N_REQ   = 3,
    parameter int  DATA_W  = DATA_W_DFLT,
    parameter int  TIMEOUT = 50_000,
    localparam int GW      = $clog2(N_REQ),
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    uart_arb_if.slave     bus,
    output logic [GW-1:0] grant_id,
    output logic          busy,
    output logic          timeout_err
);

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_WARN = CW'(TIMEOUT - 2);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    arb_state_t        state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic              tmo_q, tmo_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              full_q, full_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [GW-1:0]     pick_idx;
    logic              pick_found;
    logic              locked;
    logic              expire;
    logic              can_load;
    logic              go;
    logic              g_valid;
    logic              g_last;
    logic [DATA_W-1:0] g_data;
    logic              accept;
    logic              consume;
    logic [N_REQ-1:0]  ready;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign locked   = (state_q == LOCKED);
    // The expiry cycle closes the lock; no byte is taken in it.
    assign expire   = locked && (cnt_q == CNT_LAST);
    assign can_load = !full_q || bus.tx_ready;
    assign go       = locked && !expire && can_load;
    assign g_valid  = bus.req_valid[grant_q];
    assign g_last   = bus.req_last[grant_q];
    assign g_data   = bus.req_data[int'(grant_q)*DATA_W +: DATA_W];
    assign accept   = go && g_valid;
    assign consume  = full_q && bus.tx_ready;

    always_comb begin
        ready          = '0;
        ready[grant_q] = go;
    end

    assign bus.req_ready = ready;
    assign bus.tx_valid  = full_q;
    assign bus.tx_data   = data_q;
    assign grant_id      = grant_q;
    assign busy          = busy_q;
    assign timeout_err   = tmo_q;

    // Arbitration, message lock and stall timeout.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = LOCKED;
                    grant_d = pick_idx;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            LOCKED: begin
                if (expire) begin
                    state_d = IDLE;
                    ptr_d   = grant_q;
                    busy_d  = 1'b0;
                end else if (accept) begin
                    cnt_d = '0;
                    if (g_last) begin
                        state_d = IDLE;
                        ptr_d   = grant_q;
                        busy_d  = 1'b0;
                    end
                end else if (!g_valid) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    // Pulse lands with the counter reaching its last value.
                    tmo_d = (cnt_q == CNT_WARN);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register; a same-cycle consume and load keeps it full.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (accept) begin
            full_d = 1'b1;
            data_d = g_data;
        end else if (consume) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= GW'(N_REQ - 1);
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed messages, queued bytes.
// Driver feeds per-requester queues; monitor checks every tx transfer.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int N   = 3;
    localparam int DW  = 8;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout_err;

    uart_arb_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    uart_tx_arbiter #(
        .N_REQ   (N),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         n_tmo = 0;
    int         tmo_cyc = 0;
    int         acc_cyc [N];
    logic [8:0] sq [N][$];
    logic [7:0] exp_q [$];
    int         tx_log [$];
    logic [N-1:0] en = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Requester model: pops on handshake, presents queue heads when enabled.
    initial begin : driver
        logic [N-1:0]    acc;
        logic [N-1:0]    v;
        logic [N-1:0]    l;
        logic [N*DW-1:0] d;
        forever begin
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) acc_cyc[i] = cyc;
            end
            @(posedge clk);
            cyc++;
            #1;
            v = '0;
            l = '0;
            d = '0;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && sq[i].size() > 0) void'(sq[i].pop_front());
                if (en[i] && sq[i].size() > 0) begin
                    v[i] = 1'b1;
                    l[i] = sq[i][0][8];
                    d[i*DW +: DW] = sq[i][0][7:0];
                end
            end
            bus.req_valid = v;
            bus.req_last  = l;
            bus.req_data  = d;
        end
    end

    // Monitor: every transfer to uart_tx is checked against the queue.
    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (reset_n && timeout_err) begin
                n_tmo++;
                tmo_cyc = cyc;
            end
            if (reset_n && bus.tx_valid && bus.tx_ready) begin
                tx_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tx_unexpected: got %0h expected none",
                             bus.tx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_data", 32'(bus.tx_data), 32'(e));
                end
            end
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        en = '0;
        for (int i = 0; i < N; i++) sq[i].delete();
        exp_q.delete();
        tx_log.delete();
        n_tmo = 0;
        bus.tx_ready = 1'b1;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_busy(input logic lvl, input int lim);
        int k;
        k = 0;
        while (busy !== lvl && k < lim) begin
            tick();
            k++;
        end
    endtask

    task automatic wait_drain(input string nm, input int lim);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < lim) begin
            tick();
            k++;
        end
        chk(nm, exp_q.size(), 0);
    endtask

    initial begin : main
        logic ok;
        int   k;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_ready  = 1'b1;
        reset_n = 1'b0;
        repeat (2) tick();
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout_err, 0);
        reset_n = 1'b1;
        tick();

        // Single requester, three-byte message.
        sq[1].push_back({1'b0, 8'h41});
        sq[1].push_back({1'b0, 8'h42});
        sq[1].push_back({1'b1, 8'h43});
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h43);
        en = 3'b010;
        wait_busy(1'b1, 20);
        chk("single_grant", grant_id, 1);
        wait_busy(1'b0, 20);
        chk("single_busy_fall", cyc - acc_cyc[1], 1);
        wait_drain("single_drain", 20);
        chk("single_count", tx_log.size(), 3);
        if (tx_log.size() == 3) begin
            chk("single_gap0", tx_log[1] - tx_log[0], 1);
            chk("single_gap1", tx_log[2] - tx_log[1], 1);
        end

        // Contention: three two-byte messages at once.
        do_reset();
        sq[0].push_back({1'b0, 8'hA0});
        sq[0].push_back({1'b1, 8'hA1});
        sq[1].push_back({1'b0, 8'hB0});
        sq[1].push_back({1'b1, 8'hB1});
        sq[2].push_back({1'b0, 8'hC0});
        sq[2].push_back({1'b1, 8'hC1});
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hB0);
        exp_q.push_back(8'hB1);
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hC1);
        en = 3'b111;
        wait_drain("cont_drain", 40);
        chk("cont_count", tx_log.size(), 6);
        if (tx_log.size() == 6) begin
            chk("cont_gap0", tx_log[1] - tx_log[0], 1);
            chk("cont_gap1", tx_log[2] - tx_log[1], 2);
            chk("cont_gap2", tx_log[3] - tx_log[2], 1);
            chk("cont_gap3", tx_log[4] - tx_log[3], 2);
            chk("cont_gap4", tx_log[5] - tx_log[4], 1);
        end

        // Backpressure: byte held ten cycles.
        do_reset();
        bus.tx_ready = 1'b0;
        sq[0].push_back({1'b0, 8'hD0});
        sq[0].push_back({1'b1, 8'hD1});
        exp_q.push_back(8'hD0);
        exp_q.push_back(8'hD1);
        en = 3'b001;
        k = 0;
        while (!bus.tx_valid && k < 20) begin
            tick();
            k++;
        end
        chk("bp_full", bus.tx_valid, 1);
        chk("bp_data", bus.tx_data, 8'hD0);
        ok = 1'b1;
        repeat (10) begin
            tick();
            if (!(bus.tx_valid === 1'b1 && bus.tx_data === 8'hD0 &&
                  bus.req_ready === 3'b000)) ok = 1'b0;
        end
        chk("bp_stable", ok, 1);
        bus.tx_ready = 1'b1;
        wait_drain("bp_drain", 10);
        chk("bp_count", tx_log.size(), 2);
        if (tx_log.size() == 2) chk("bp_gap", tx_log[1] - tx_log[0], 1);

        // Timeout: req 0 stalls mid-message while req 2 waits.
        do_reset();
        sq[0].push_back({1'b0, 8'hE0});
        sq[2].push_back({1'b1, 8'hF0});
        exp_q.push_back(8'hE0);
        exp_q.push_back(8'hF0);
        en = 3'b101;
        k = 0;
        while (n_tmo == 0 && k < 40) begin
            tick();
            k++;
        end
        chk("tmo_seen", n_tmo, 1);
        chk("tmo_delay", tmo_cyc - acc_cyc[0], 16);
        wait_busy(1'b1, 10);
        chk("tmo_regrant_delay", cyc - tmo_cyc, 2);
        chk("tmo_regrant_id", grant_id, 2);
        wait_drain("tmo_drain", 20);
        chk("tmo_single_pulse", n_tmo, 1);

        // Reset while the output register is full.
        do_reset();
        bus.tx_ready = 1'b0;
        sq[0].push_back({1'b0, 8'h60});
        sq[0].push_back({1'b1, 8'h61});
        en = 3'b001;
        k = 0;
        while (!bus.tx_valid && k < 20) begin
            tick();
            k++;
        end
        chk("mid_full", bus.tx_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_async_valid", bus.tx_valid, 0);
        en = '0;
        for (int i = 0; i < N; i++) sq[i].delete();
        tick();
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", bus.tx_data, 0);
        reset_n = 1'b1;
        bus.tx_ready = 1'b1;
        tick();
        chk("mid_rel_valid", bus.tx_valid, 0);
        chk("mid_rel_grant", grant_id, 0);
        chk("mid_rel_ready", bus.req_ready, 0);
        sq[0].push_back({1'b1, 8'h70});
        sq[1].push_back({1'b1, 8'h80});
        exp_q.push_back(8'h70);
        exp_q.push_back(8'h80);
        en = 3'b011;
        wait_drain("mid_drain", 20);

        // Fairness: single-byte messages alternate 0,1,0,1.
        do_reset();
        sq[0].push_back({1'b1, 8'h90});
        sq[0].push_back({1'b1, 8'h91});
        sq[0].push_back({1'b1, 8'h92});
        sq[1].push_back({1'b1, 8'hC5});
        sq[1].push_back({1'b1, 8'hC6});
        sq[1].push_back({1'b1, 8'hC7});
        exp_q.push_back(8'h90);
        exp_q.push_back(8'hC5);
        exp_q.push_back(8'h91);
        exp_q.push_back(8'hC6);
        exp_q.push_back(8'h92);
        exp_q.push_back(8'hC7);
        en = 3'b011;
        wait_drain("fair_drain", 60);
        chk("fair_count", tx_log.size(), 6);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single `uart_tx` byte transmitter between several byte-stream requesters: the command translator, a telemetry source for distance/direction, and a debug echo. Requesters present bytes with valid/ready handshakes and mark message ends with `last`. The block grants the transmitter round-robin per message, so multi-byte messages are never interleaved. It sits between the requesters and `uart_tx` on `clk_50`, and releases a stalled message after a timeout.

## Interface
- `N_REQ`, 3: number of requesters (2..8).
- `DATA_W`, 8: byte width.
- `TIMEOUT`, 50_000: idle cycles allowed mid-message before the lock is force-released.
- `clk`  in  1: system clock (`clk_50`).
- `reset_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  N_REQ: per-requester byte valid.
- `req_data`  in  N_REQ*DATA_W: per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W].
- `req_last`  in  N_REQ: byte is the final byte of its message.
- `req_ready`  out  N_REQ: byte accepted from requester i when `req_valid[i] && req_ready[i]`.
- `tx_data`  out  DATA_W: byte to `uart_tx.data_tx`.
- `tx_valid`  out  1: to `uart_tx.valid`.
- `tx_ready`  in  1: from `uart_tx.tx_ready`; a byte is consumed when `tx_valid && tx_ready`.
- `grant_id`  out  $clog2(N_REQ): index of the current or most recent grant.
- `busy`  out  1: high while a message is locked.
- `timeout_err`  out  1: one-cycle pulse on forced release.

## Operation
- States: IDLE, LOCKED.
- IDLE: if any `req_valid` is high, pick the first requester found searching upward from `ptr+1` modulo N_REQ. Register its index into `grant_id`, set `busy`, and go to LOCKED. `ptr` is the last granted index; it resets to N_REQ-1, so requester 0 wins first.
- LOCKED: only `req_ready[grant_id]` may be high. All other `req_ready` bits stay 0.
- Output register: one byte plus a full flag.
  - `req_ready[g] = LOCKED && (!full || tx_ready)`.
  - On accept, load the byte and set full.
  - On consume with no accept in the same cycle, clear full.
  - `tx_valid = full`. `tx_data` holds its value while full.
- On accept with `req_last=1`: set `ptr <= grant_id`, go to IDLE, clear `busy`. The already-loaded byte still drains from the output register. Arbitration may run while it drains.
- Timeout counter:
  - Clears on every accept and on entry to LOCKED.
  - Increments each LOCKED cycle with `req_valid[g]=0`.
  - At `TIMEOUT-1`: pulse `timeout_err`, update `ptr`, go to IDLE. The requester's remaining bytes then compete as a new message.
- Counter width is $clog2(TIMEOUT+1). It saturates and never wraps.
- A requester that deasserts `req_valid` mid-message keeps the lock until timeout. No other requester is served meanwhile.

## Timing
- Values after reset: `tx_valid=0`, `tx_data=0`, `req_ready=0`, `grant_id=0`, `busy=0`, `timeout_err=0`, state IDLE, full=0, counter 0.
- Reset asserted mid-message: the byte in the output register is dropped and no partial handshake completes. After release, the block resumes from IDLE.
- Requests seen in IDLE at cycle t: grant registered at t+1, first accept possible at t+1, `tx_valid` high at t+2.
- Sustained throughput is one byte per cycle when `tx_ready` stays high. That means `req_ready` stays high through back-to-back bytes, because of the simultaneous load/consume path.
- Message turnaround: `last` accepted at t, IDLE at t+1, next grant at t+2. There is one bubble cycle per message boundary.
- Simultaneous consume and accept in the same cycle: the register reloads and full stays 1.
- `req_ready` is combinational from `tx_ready`. `tx_valid` and `tx_data` are registered outputs.

## Structure
- Package `uart_arb_pkg`:
  - `arb_state_t` enum (IDLE, LOCKED).
  - `DATA_W` default.
  - Command byte framing constants shared with `command_translator`.
- Sub-module `rr_pick`: combinational rotate-priority search. Inputs are `req[N_REQ]` and `ptr`; outputs are `idx` and `found`. It is reused by any later arbiter.
- The top holds the FSM, the output register and the timeout counter.

## Test plan
- Single requester: req 1 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) with `tx_ready`=1 -> `grant_id`=1, bytes appear on `tx_data` in order on consecutive cycles, `busy` falls after 0x43 is accepted.
- Contention: all three request 2-byte messages simultaneously from reset -> message order 0,1,2 with no interleaving, one bubble cycle between messages.
- Backpressure: `tx_ready` low for 10 cycles with a byte held -> `tx_valid` and `tx_data` stable, `req_ready` 0. `tx_ready` high -> the held byte and the next byte transfer on consecutive cycles.
- Timeout: with `TIMEOUT`=16, req 0 sends 1 byte without `last`, then drops valid while req 2 is waiting -> `timeout_err` pulses exactly 16 cycles after the last accept, req 2 granted 2 cycles later.
- Reset mid-message: `reset_n` low while full=1 -> `tx_valid` drops immediately (asynchronous). After release, all outputs are at reset values and requester 0 has priority.
- Fairness: req 0 requests back-to-back single-byte messages and req 1 requests continuously -> grants alternate 0,1,0,1.
